// File: rtl/keypad_scan_if.sv
// Status/acknowledge bundle between keypad_scan and the peripheral read logic.
// The slave modport is the scanner side and the master modport is the reader side.
interface keypad_scan_if;
  logic       ack;
  logic [3:0] key_code;
  logic       key_down;
  logic       key_pending;
  logic       key_overrun;
  logic       key_irq;

  modport master (
    output ack,
    input  key_code,
    input  key_down,
    input  key_pending,
    input  key_overrun,
    input  key_irq
  );

  modport slave (
    input  ack,
    output key_code,
    output key_down,
    output key_pending,
    output key_overrun,
    output key_irq
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with frame-based press/release debounce and sticky status.
// Optional macro KEYPAD_IRQ_EN: key_irq is key_pending delayed one clock; otherwise it is 0.
module keypad_scan #(
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    io_keypad_row,
  output logic [3:0]    io_keypad_col,
  keypad_scan_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StDebPress, StDown, StDebRelease} state_e;

  localparam logic [15:0] SlotLast = 16'(SCAN_CYCLES - 1);
  localparam logic [3:0]  DebLast  = 4'(DEBOUNCE_FRAMES);
  localparam bit          DebOne   = (DEBOUNCE_FRAMES == 1);

  logic [15:0] r_slot_cnt;
  logic [1:0]  r_col;
  logic [3:0]  r_col_drive;
  logic [15:0] r_frame;
  state_e      r_state;
  logic [3:0]  r_deb_cnt;
  logic [3:0]  r_cand;
  logic [3:0]  r_key_code;
  logic        r_key_down;
  logic        r_pending;
  logic        r_overrun;

  logic        w_slot_last;
  logic        w_frame_end;
  logic [15:0] w_frame_now;
  logic        w_empty;
  logic [3:0]  w_cand;
  logic        w_confirm;

  assign w_slot_last = (r_slot_cnt == SlotLast);
  assign w_frame_end = w_slot_last && (r_col == 2'd3);

  // Frame image including the rows seen on this clock for the current column.
  always_comb begin
    w_frame_now = r_frame;
    if (w_slot_last) begin
      for (int r = 0; r < 4; r++) begin
        w_frame_now[4 * r + int'(r_col)] = ~io_keypad_row[r];
      end
    end
  end

  assign w_empty = (w_frame_now == 16'h0000);

  // Lowest set index wins when several keys are down.
  always_comb begin
    w_cand = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (w_frame_now[i]) begin
        w_cand = 4'(i);
      end
    end
  end

  assign w_confirm = w_frame_end && !w_empty &&
                     ((r_state == StIdle && DebOne) ||
                      (r_state == StDebPress && w_cand == r_cand &&
                       (r_deb_cnt + 4'd1) >= DebLast));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_cnt  <= 16'd0;
      r_col       <= 2'd0;
      r_col_drive <= 4'b1110;
      r_frame     <= 16'h0000;
    end else if (w_slot_last) begin
      r_slot_cnt  <= 16'd0;
      r_col       <= r_col + 2'd1;
      r_col_drive <= {r_col_drive[2:0], r_col_drive[3]};
      r_frame     <= w_frame_now;
    end else begin
      r_slot_cnt  <= r_slot_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_deb_cnt  <= 4'd0;
      r_cand     <= 4'd0;
      r_key_code <= 4'd0;
      r_key_down <= 1'b0;
      r_pending  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (bus.ack) begin
        r_pending <= 1'b0;
        r_overrun <= 1'b0;
      end
      // Later assignments override the ack clear, so a coincident confirm wins.
      if (w_confirm) begin
        r_state    <= StDown;
        r_deb_cnt  <= 4'd0;
        r_key_code <= w_cand;
        r_key_down <= 1'b1;
        r_pending  <= 1'b1;
        r_overrun  <= r_overrun | r_pending;
      end else if (w_frame_end) begin
        unique case (r_state)
          StIdle: begin
            if (!w_empty) begin
              r_state   <= StDebPress;
              r_cand    <= w_cand;
              r_deb_cnt <= 4'd1;
            end
          end
          StDebPress: begin
            if (w_empty) begin
              r_state   <= StIdle;
              r_deb_cnt <= 4'd0;
            end else if (w_cand != r_cand) begin
              r_cand    <= w_cand;
              r_deb_cnt <= 4'd1;
            end else begin
              r_deb_cnt <= r_deb_cnt + 4'd1;
            end
          end
          StDown: begin
            if (w_empty) begin
              if (DebOne) begin
                r_state    <= StIdle;
                r_deb_cnt  <= 4'd0;
                r_key_down <= 1'b0;
              end else begin
                r_state   <= StDebRelease;
                r_deb_cnt <= 4'd1;
              end
            end
          end
          StDebRelease: begin
            if (!w_empty) begin
              r_state   <= StDown;
              r_deb_cnt <= 4'd0;
            end else if ((r_deb_cnt + 4'd1) >= DebLast) begin
              r_state    <= StIdle;
              r_deb_cnt  <= 4'd0;
              r_key_down <= 1'b0;
            end else begin
              r_deb_cnt <= r_deb_cnt + 4'd1;
            end
          end
        endcase
      end
    end
  end

`ifdef KEYPAD_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_pending;
    end
  end

  assign bus.key_irq = r_irq;
`else
  assign bus.key_irq = 1'b0;
`endif

  assign io_keypad_col   = r_col_drive;
  assign bus.key_code    = r_key_code;
  assign bus.key_down    = r_key_down;
  assign bus.key_pending = r_pending;
  assign bus.key_overrun = r_overrun;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: keypad matrix model, frame-level reference model,
// directed scenarios followed by randomized frames.
module tb_keypad_scan;
  localparam int unsigned SC = 4;
  localparam int unsigned DF = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] keys;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, tracked per frame.
  int         m_streak;
  int         m_prev;
  int         m_empty;
  bit         m_down;
  bit         m_pend;
  bit         m_ovr;
  logic [3:0] m_code;

  keypad_scan_if u_bus ();

  keypad_scan #(
    .SCAN_CYCLES     (SC),
    .DEBOUNCE_FRAMES (DF)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .io_keypad_row (row),
    .io_keypad_col (col),
    .bus           (u_bus)
  );

  always #5 clk = ~clk;

  // A held key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[4 * r + c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic int cand_of(input logic [15:0] k);
    for (int i = 0; i < 16; i++) begin
      if (k[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_streak = 0;
    m_prev   = -1;
    m_empty  = 0;
    m_down   = 1'b0;
    m_pend   = 1'b0;
    m_ovr    = 1'b0;
    m_code   = 4'd0;
  endtask

  task automatic check_status(input string tag, input bit exp_irq);
    chk({tag, "_down"}, {3'b0, u_bus.key_down}, {3'b0, m_down});
    chk({tag, "_code"}, u_bus.key_code, m_code);
    chk({tag, "_pend"}, {3'b0, u_bus.key_pending}, {3'b0, m_pend});
    chk({tag, "_ovr"}, {3'b0, u_bus.key_overrun}, {3'b0, m_ovr});
    chk({tag, "_irq"}, {3'b0, u_bus.key_irq}, {3'b0, exp_irq});
  endtask

  // Holds keys k for one whole frame, optionally pulsing ack on the given edge.
  task automatic run_frame(input logic [15:0] k, input bit do_ack, input int ack_edge);
    logic [3:0] exp_col;
    int  cand;
    bit  pre;
    bit  conf;
    bit  exp_irq;
    keys = k;
    for (int i = 0; i < 16; i++) begin
      u_bus.ack = do_ack && (i == ack_edge);
      @(posedge clk);
      #1;
      u_bus.ack = 1'b0;
      if (do_ack && i == ack_edge && i != 15) begin
        m_pend = 1'b0;
        m_ovr  = 1'b0;
        chk("ack_pend", {3'b0, u_bus.key_pending}, 4'd0);
        chk("ack_ovr", {3'b0, u_bus.key_overrun}, 4'd0);
      end
      if (i % 4 >= 2) begin
        exp_col = 4'b1111;
        exp_col[((i + 1) / 4) % 4] = 1'b0;
        chk("col", col, exp_col);
      end
    end
    cand = cand_of(k);
    pre  = m_pend;
    conf = 1'b0;
    if (!m_down) begin
      if (cand < 0) m_streak = 0;
      else if (m_streak > 0 && cand == m_prev) m_streak++;
      else m_streak = 1;
      m_prev = cand;
      if (m_streak >= DF) begin
        conf    = 1'b1;
        m_down  = 1'b1;
        m_code  = 4'(cand);
        m_ovr   = m_ovr | m_pend;
        m_pend  = 1'b1;
        m_empty = 0;
      end
    end else if (cand < 0) begin
      m_empty++;
      if (m_empty >= DF) begin
        m_down   = 1'b0;
        m_streak = 0;
        m_empty  = 0;
      end
    end else begin
      m_empty = 0;
    end
    if (do_ack && ack_edge == 15 && !conf) begin
      m_pend = 1'b0;
      m_ovr  = 1'b0;
    end
`ifdef KEYPAD_IRQ_EN
    exp_irq = pre;
`else
    exp_irq = 1'b0;
`endif
    check_status("frame", exp_irq);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_col", col, 4'b1110);
    check_status("rst", 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [15:0] k;
    logic [15:0] prev_k;
    int          sel;

    rst       = 1'b1;
    keys      = 16'h0000;
    u_bus.ack = 1'b0;
    model_reset();

    // Key 6 held from reset: confirm at end of frame 1.
    do_reset();
    keys = 16'h0040;
    run_frame(16'h0040, 1'b0, 0);
    run_frame(16'h0040, 1'b0, 0);
    chk("k6_down", {3'b0, u_bus.key_down}, 4'd1);
    chk("k6_code", u_bus.key_code, 4'd6);
    chk("k6_pend", {3'b0, u_bus.key_pending}, 4'd1);

    // Bounce: present in one frame only.
    do_reset();
    run_frame(16'h0040, 1'b0, 0);
    run_frame(16'h0000, 1'b0, 0);
    run_frame(16'h0000, 1'b0, 0);
    chk("bounce_pend", {3'b0, u_bus.key_pending}, 4'd0);
    chk("bounce_down", {3'b0, u_bus.key_down}, 4'd0);

    // Keys 9 and 4 together: lowest index wins, code held after release.
    do_reset();
    run_frame(16'h0210, 1'b0, 0);
    run_frame(16'h0210, 1'b0, 0);
    chk("multi_code", u_bus.key_code, 4'd4);
    run_frame(16'h0000, 1'b0, 0);
    chk("multi_still_down", {3'b0, u_bus.key_down}, 4'd1);
    run_frame(16'h0000, 1'b0, 0);
    chk("multi_up", {3'b0, u_bus.key_down}, 4'd0);
    chk("multi_code_held", u_bus.key_code, 4'd4);

    // Overrun: key 3 then key 12 without ack, then ack clears both.
    do_reset();
    run_frame(16'h0008, 1'b0, 0);
    run_frame(16'h0008, 1'b0, 0);
    run_frame(16'h0000, 1'b0, 0);
    run_frame(16'h0000, 1'b0, 0);
    run_frame(16'h1000, 1'b0, 0);
    run_frame(16'h1000, 1'b0, 0);
    chk("ovr_code", u_bus.key_code, 4'd12);
    chk("ovr_set", {3'b0, u_bus.key_overrun}, 4'd1);
    run_frame(16'h1000, 1'b1, 5);
    chk("ovr_cleared", {3'b0, u_bus.key_overrun}, 4'd0);

    // Ack coincident with the confirm of key 5.
    run_frame(16'h0000, 1'b0, 0);
    run_frame(16'h0000, 1'b0, 0);
    run_frame(16'h0020, 1'b0, 0);
    run_frame(16'h0020, 1'b1, 15);
    chk("coinc_code", u_bus.key_code, 4'd5);
    chk("coinc_pend", {3'b0, u_bus.key_pending}, 4'd1);
    chk("coinc_ovr", {3'b0, u_bus.key_overrun}, 4'd0);

    // Randomized frames against the model.
    do_reset();
    prev_k = 16'h0000;
    for (int f = 0; f < 80; f++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 5) k = prev_k;
      else if (sel < 7) k = 16'h0000;
      else begin
        k = 16'h0000;
        k[$urandom_range(0, 15)] = 1'b1;
        if (sel == 9) k[$urandom_range(0, 15)] = 1'b1;
      end
      run_frame(k, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)));
      prev_k = k;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
